// File: rtl/mu_pkg.sv
// Shared types and default widths for the measure-unit delay sweep sequencer.
package mu_pkg;

    localparam int CODE_W_DEF = 10;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_STROBE,
        ST_EMIT,
        ST_NEXT
    } sweep_state_e;

endpackage

// File: rtl/mu_sweep_seq.sv
// Delay-code sweep sequencer: steps a delay line through a code range, collects
// comparator hit counts per code and hands each (code, hits) point out on a handshake.
module mu_sweep_seq
    import mu_pkg::*;
#(
    parameter int CODE_W        = CODE_W_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CODE_W-1:0] code_start_i,
    input  logic [CODE_W-1:0] code_stop_i,
    input  logic [CODE_W-1:0] code_step_i,
    input  logic [CNT_W-1:0]  samples_i,
    output logic [CODE_W-1:0] delay_code_o,
    output logic              stb_req_o,
    input  logic              stb_ack_i,
    input  logic              cmp_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CODE_W-1:0] res_code_o,
    output logic [CNT_W-1:0]  res_hits_o,
    output logic              busy_o,
    output logic              done_o
);

    sweep_state_e      state_reg;
    logic [CODE_W-1:0] stop_reg;
    logic [CODE_W-1:0] step_reg;
    logic [CNT_W-1:0]  target_reg;
    logic [7:0]        settle_cnt_reg;
    logic [CNT_W-1:0]  sample_cnt_reg;
    logic [CNT_W-1:0]  hit_cnt_reg;
    logic [CODE_W-1:0] delay_code_reg;
    logic              stb_req_reg;
    logic              res_valid_reg;
    logic [CODE_W-1:0] res_code_reg;
    logic [CNT_W-1:0]  res_hits_reg;
    logic              done_reg;

    // One extra bit so a sum past the top of the code space ends the sweep instead of wrapping.
    logic [CODE_W:0]   sum_next;
    logic [CNT_W-1:0]  hits_next;
    logic [CNT_W-1:0]  samples_next;
    logic              sweep_end;

    assign sum_next     = {1'b0, delay_code_reg} + {1'b0, step_reg};
    assign hits_next    = hit_cnt_reg + CNT_W'(cmp_i);
    assign samples_next = sample_cnt_reg + CNT_W'(1);
    assign sweep_end    = sum_next[CODE_W] || (sum_next[CODE_W-1:0] > stop_reg);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg      <= ST_IDLE;
            stop_reg       <= '0;
            step_reg       <= '0;
            target_reg     <= '0;
            settle_cnt_reg <= '0;
            sample_cnt_reg <= '0;
            hit_cnt_reg    <= '0;
            delay_code_reg <= '0;
            stb_req_reg    <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_code_reg   <= '0;
            res_hits_reg   <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (abort_i) begin
                state_reg     <= ST_IDLE;
                stb_req_reg   <= 1'b0;
                res_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start_i) begin
                            stop_reg       <= code_stop_i;
                            step_reg       <= (code_step_i == '0) ? CODE_W'(1) : code_step_i;
                            target_reg     <= (samples_i == '0) ? CNT_W'(1) : samples_i;
                            delay_code_reg <= code_start_i;
                            settle_cnt_reg <= '0;
                            sample_cnt_reg <= '0;
                            hit_cnt_reg    <= '0;
                            state_reg      <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_reg == 8'(SETTLE_CYCLES - 1)) begin
                            settle_cnt_reg <= '0;
                            stb_req_reg    <= 1'b1;
                            state_reg      <= ST_STROBE;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg + 8'd1;
                        end
                    end
                    ST_STROBE: begin
                        if (stb_ack_i) begin
                            hit_cnt_reg    <= hits_next;
                            sample_cnt_reg <= samples_next;
                            if (samples_next == target_reg) begin
                                stb_req_reg   <= 1'b0;
                                res_valid_reg <= 1'b1;
                                res_code_reg  <= delay_code_reg;
                                res_hits_reg  <= hits_next;
                                state_reg     <= ST_EMIT;
                            end
                        end
                    end
                    ST_EMIT: begin
                        if (res_ready_i) begin
                            res_valid_reg <= 1'b0;
                            state_reg     <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (sweep_end) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            delay_code_reg <= sum_next[CODE_W-1:0];
                            sample_cnt_reg <= '0;
                            hit_cnt_reg    <= '0;
                            state_reg      <= ST_SETTLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign delay_code_o = delay_code_reg;
    assign stb_req_o    = stb_req_reg;
    assign res_valid_o  = res_valid_reg;
    assign res_code_o   = res_code_reg;
    assign res_hits_o   = res_hits_reg;
    assign busy_o       = (state_reg != ST_IDLE);
    assign done_o       = done_reg;

endmodule

// File: tb/tb_mu_sweep_seq.sv
// Randomized bench for mu_sweep_seq: expected sweep points come from plain range arithmetic,
// expected hit counts from the queue of comparator values the bench itself acknowledged.
module tb_mu_sweep_seq;

    localparam int CODE_W   = 10;
    localparam int CNT_W    = 16;
    localparam int CODE_MAX = (1 << CODE_W) - 1;

    logic              clk = 1'b0;
    logic              srst;
    logic              start_i, abort_i;
    logic [CODE_W-1:0] code_start_i, code_stop_i, code_step_i;
    logic [CNT_W-1:0]  samples_i;
    logic [CODE_W-1:0] delay_code_o;
    logic              stb_req_o, stb_ack_i, cmp_i;
    logic              res_valid_o, res_ready_i;
    logic [CODE_W-1:0] res_code_o;
    logic [CNT_W-1:0]  res_hits_o;
    logic              busy_o, done_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mu_sweep_seq #(.CODE_W(CODE_W), .CNT_W(CNT_W), .SETTLE_CYCLES(16)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (srst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .code_start_i (code_start_i),
        .code_stop_i  (code_stop_i),
        .code_step_i  (code_step_i),
        .samples_i    (samples_i),
        .delay_code_o (delay_code_o),
        .stb_req_o    (stb_req_o),
        .stb_ack_i    (stb_ack_i),
        .cmp_i        (cmp_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_code_o   (res_code_o),
        .res_hits_o   (res_hits_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code"},  32'(delay_code_o), 0);
        check({tag, "_stb"},   32'(stb_req_o),    0);
        check({tag, "_valid"}, 32'(res_valid_o),  0);
        check({tag, "_rcode"}, 32'(res_code_o),   0);
        check({tag, "_rhits"}, 32'(res_hits_o),   0);
        check({tag, "_busy"},  32'(busy_o),       0);
        check({tag, "_done"},  32'(done_o),       0);
    endtask

    task automatic idle_inputs();
        start_i     = 1'b0;
        abort_i     = 1'b0;
        stb_ack_i   = 1'b0;
        cmp_i       = 1'b0;
        res_ready_i = 1'b0;
    endtask

    // cmp_mode: 0 random, 1 always one, 2 alternating 1,0 per acknowledged sample.
    task automatic run_sweep(input string name, input int cs, input int ce, input int cst,
                             input int smp, input int ack_pct, input int rdy_pct,
                             input int rdy_hold, input int cmp_mode, input int abort_pt);
        int  pts[$];
        bit  ack_q[$];
        int  c, stepe, tgt, emitted, valid_cnt, hits;
        bit  alt, got_done, aborted, hold_pending;
        logic [CODE_W-1:0] hold_code;
        logic [CNT_W-1:0]  hold_hits;

        stepe = (cst == 0) ? 1 : cst;
        tgt   = (smp == 0) ? 1 : smp;
        c = cs;
        do begin
            pts.push_back(c);
            c += stepe;
        end while (c <= ce && c <= CODE_MAX);

        code_start_i = CODE_W'(cs);
        code_stop_i  = CODE_W'(ce);
        code_step_i  = CODE_W'(cst);
        samples_i    = CNT_W'(smp);
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        code_start_i = CODE_W'($urandom);
        code_stop_i  = CODE_W'($urandom);
        code_step_i  = CODE_W'($urandom);
        samples_i    = CNT_W'($urandom);
        check({name, "_load"}, 32'(delay_code_o), 32'(cs));

        emitted = 0; valid_cnt = 0; alt = 1'b1;
        got_done = 1'b0; aborted = 1'b0; hold_pending = 1'b0;
        hold_code = '0; hold_hits = '0;

        for (int k = 0; k < 20000 && !got_done && !aborted; k++) begin
            if (res_valid_o && hold_pending) begin
                check({name, "_hold_code"}, 32'(res_code_o), 32'(hold_code));
                check({name, "_hold_hits"}, 32'(res_hits_o), 32'(hold_hits));
            end
            if (done_o) begin
                check({name, "_npts"}, 32'(emitted), 32'(pts.size()));
                got_done = 1'b1;
            end else if (abort_pt >= 0 && stb_req_o && emitted == abort_pt) begin
                abort_i = 1'b1; stb_ack_i = 1'b0; start_i = 1'b0; res_ready_i = 1'b0;
                tick();
                abort_i = 1'b0;
                check({name, "_abort_stb"},   32'(stb_req_o),    0);
                check({name, "_abort_busy"},  32'(busy_o),       0);
                check({name, "_abort_valid"}, 32'(res_valid_o),  0);
                check({name, "_abort_done"},  32'(done_o),       0);
                check({name, "_abort_code"},  32'(delay_code_o), 32'(pts[abort_pt]));
                repeat (20) tick();
                check({name, "_abort_nodone"}, 32'(done_o | busy_o), 0);
                check({name, "_abort_hold"},   32'(delay_code_o), 32'(pts[abort_pt]));
                aborted = 1'b1;
            end else begin
                stb_ack_i = stb_req_o && ($urandom_range(0, 99) < ack_pct);
                case (cmp_mode)
                    1:       cmp_i = 1'b1;
                    2:       cmp_i = alt;
                    default: cmp_i = 1'($urandom_range(0, 1));
                endcase
                if (stb_ack_i) begin
                    ack_q.push_back(cmp_i);
                    alt = ~alt;
                end
                valid_cnt   = res_valid_o ? valid_cnt + 1 : 0;
                res_ready_i = (valid_cnt > rdy_hold) && ($urandom_range(0, 99) < rdy_pct);
                start_i     = busy_o && ($urandom_range(0, 7) == 0);
                if (res_valid_o && res_ready_i) begin
                    check({name, "_in_range"}, 32'(emitted < pts.size()), 1);
                    if (emitted < pts.size()) begin
                        check({name, "_code"}, 32'(res_code_o), 32'(pts[emitted]));
                        check({name, "_nsamp"}, 32'(ack_q.size()), 32'(tgt));
                        hits = 0;
                        while (ack_q.size() > 0) hits += int'(ack_q.pop_front());
                        check({name, "_hits"}, 32'(res_hits_o), 32'(hits));
                    end
                    emitted++;
                    hold_pending = 1'b0;
                end else begin
                    hold_pending = res_valid_o;
                    hold_code    = res_code_o;
                    hold_hits    = res_hits_o;
                end
                tick();
            end
        end
        idle_inputs();
        if (!got_done && !aborted) check({name, "_timeout"}, 0, 1);
        if (got_done) begin
            tick();
            check({name, "_done_pulse"}, 32'(done_o), 0);
            check({name, "_idle"},       32'(busy_o), 0);
            check({name, "_code_held"},  32'(delay_code_o), 32'(pts[pts.size()-1]));
        end
        $display("sweep %s: start=%0d stop=%0d step=%0d samples=%0d points=%0d emitted=%0d",
                 name, cs, ce, cst, smp, pts.size(), emitted);
    endtask

    initial begin
        int cs, ce;
        idle_inputs();
        code_start_i = '0; code_stop_i = '0; code_step_i = '0; samples_i = '0;

        // Reset state.
        srst = 1'b1;
        repeat (2) tick();
        check_reset_outputs("reset");
        srst = 1'b0;
        tick();

        // Abort together with start in IDLE keeps the FSM idle.
        code_start_i = 10'd33; code_stop_i = 10'd40; code_step_i = 10'd1; samples_i = 16'd1;
        start_i = 1'b1; abort_i = 1'b1;
        tick();
        idle_inputs();
        check("abort_start_busy", 32'(busy_o), 0);
        $display("step abort+start in idle: busy=%0d", busy_o);

        // Strobe latency after start.
        code_start_i = 10'd5;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("lat_code",  32'(delay_code_o), 5);
        check("lat_busy",  32'(busy_o), 1);
        repeat (15) tick();
        check("lat_stb16", 32'(stb_req_o), 0);
        tick();
        check("lat_stb17", 32'(stb_req_o), 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("lat_abort_busy", 32'(busy_o), 0);
        $display("step latency: stb_req high at cycle 17");

        run_sweep("basic",    0,    4,   2, 3, 100, 100, 0,  1, -1);
        run_sweep("stall",    100,  120, 10, 4, 100, 100, 10, 2, -1);
        run_sweep("top",      1020, 1023, 5, 2, 60,  70,  0,  0, -1);
        run_sweep("abort",    10,   40,  10, 3, 70,  80,  0,  0, 1);
        run_sweep("zero",     7,    7,   0, 0, 100, 100, 0,  0, -1);
        run_sweep("reverse",  300,  200, 3, 2, 50,  50,  0,  0, -1);

        for (int r = 0; r < 5; r++) begin
            cs = $urandom_range(0, CODE_MAX);
            ce = cs + $urandom_range(0, 60);
            if (ce > CODE_MAX) ce = CODE_MAX;
            if ($urandom_range(0, 4) == 0) ce = $urandom_range(0, CODE_MAX);
            run_sweep($sformatf("rand%0d", r), cs, ce, $urandom_range(0, 15),
                      $urandom_range(0, 5), $urandom_range(30, 100), $urandom_range(30, 100),
                      $urandom_range(0, 3), 0, -1);
        end

        // Reset mid-sweep, asserted together with start and abort.
        code_start_i = 10'd100; code_stop_i = 10'd200; code_step_i = 10'd10; samples_i = 16'd2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            stb_ack_i   = stb_req_o;
            cmp_i       = 1'b1;
            res_ready_i = 1'b0;
            tick();
        end
        srst = 1'b1; start_i = 1'b1; abort_i = 1'b1;
        tick();
        srst = 1'b0;
        idle_inputs();
        check_reset_outputs("midrst");
        $display("step reset mid-sweep: code=%0d busy=%0d", delay_code_o, busy_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
